// File: rtl/mult_seq_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encoding and the default operand width.
package mult_seq_ctrl_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mult_seq_ctrl_adder_ripple.sv
// Gate-level ripple-carry adder: a half adder at bit 0 and
// full adders above it, used as the shared multiplier datapath adder.
module adder_ripple #(
    parameter int WIDTH = 4
) (
    output logic             c_out,
    output logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b
);

    logic [WIDTH:1] c;

    assign sum[0] = a[0] ^ b[0];
    assign c[1]   = a[0] & b[0];

    for (genvar i = 1; i < WIDTH; i++) begin : g_fa
        logic p;
        assign p        = a[i] ^ b[i];
        assign sum[i]   = p ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (p & c[i]);
    end

    assign c_out = c[WIDTH];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier controller: one WIDTH-bit adder,
// reused once per cycle over WIDTH steps, with a start/done handshake.
module mult_seq_ctrl
    import mult_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e               state_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH:0]     p_q;
    logic [2*WIDTH:0]     p_d;
    logic [CW-1:0]        count_q;
    logic [2*WIDTH-1:0]   product_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 add_co;
    logic [WIDTH-1:0]     add_sum;
    logic [WIDTH:0]       acc_d;

    adder_ripple #(
        .WIDTH(WIDTH)
    ) u_add (
        .c_out(add_co),
        .sum  (add_sum),
        .a    (p_q[2*WIDTH-1:WIDTH]),
        .b    (mcand_q)
    );

    // The accumulator's top bit is always clear between steps, so the
    // carry-out of the WIDTH-bit add lands there without loss.
    always_comb begin
        acc_d = p_q[2*WIDTH:WIDTH];
        if (p_q[0]) begin
            acc_d = {add_co, add_sum};
        end
        p_d = {1'b0, acc_d, p_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            p_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q <= a;
                        p_q     <= {{(WIDTH+1){1'b0}}, b};
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    p_q     <= p_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST) begin
                        product_q <= p_d[2*WIDTH-1:0];
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
